// File: rtl/thread_fetch_unit_pkg.sv
// Shared sizing, instruction constants and the fetch tag carried alongside each
// instruction-memory read.
package fetch_pkg;

  localparam int NUM_THREADS = 4;
  localparam int TID_W       = 2;
  localparam int PC_W        = 9;
  localparam int DATA_W      = 32;

  localparam logic [DATA_W-1:0] HALT_WORD = 32'hEAFFFFFE;
  localparam logic [DATA_W-1:0] NOP_WORD  = 32'hE1A00000;

  typedef struct packed {
    logic             valid;
    logic [TID_W-1:0] thread;
    logic [PC_W-1:0]  pc;
  } fetch_tag_t;

endpackage

// File: rtl/thread_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, downstream valid/ready
// stream and the execute-stage redirect request.
interface thread_fetch_unit_if;
  import fetch_pkg::*;

  logic [PC_W-1:0]   imem_addr;
  logic [TID_W-1:0]  imem_thread;
  logic [DATA_W-1:0] imem_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [TID_W-1:0]  out_thread;
  logic [PC_W-1:0]   out_pc;

  logic              redirect_valid;
  logic [TID_W-1:0]  redirect_thread;
  logic [PC_W-1:0]   redirect_pc;

  modport master (
    output imem_addr, imem_thread, out_valid, out_instr, out_thread, out_pc,
    input  imem_rdata, out_ready, redirect_valid, redirect_thread, redirect_pc
  );

  modport slave (
    input  imem_addr, imem_thread, out_valid, out_instr, out_thread, out_pc,
    output imem_rdata, out_ready, redirect_valid, redirect_thread, redirect_pc
  );

endinterface

// File: rtl/thread_fetch_unit_rr_arbiter.sv
// Combinational round-robin pick: search begins one past the last grant and the
// first requesting thread wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;

  // N is a power of two, so the IW-bit add wraps the search pointer for free
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = last_i + IW'(k);
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/thread_fetch_unit.sv
// Barrel-processor fetch front end: per-thread PCs, round-robin issue, one-entry hold buffer.
// THREAD_FETCH_HALT_DETECT_EN: accepted HALT_WORD parks its thread until redirected.
module thread_fetch_unit
  import fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_THREADS-1:0] thread_en_i,
  output logic [NUM_THREADS-1:0] halted_o,
  thread_fetch_unit_if.master    fetch_if
);

  logic [PC_W-1:0]        pc_q [NUM_THREADS];
  logic [PC_W-1:0]        pc_d [NUM_THREADS];
  logic [TID_W-1:0]       last_q, last_d;
  logic [PC_W-1:0]        imem_addr_q, imem_addr_d;
  logic [TID_W-1:0]       imem_thread_q, imem_thread_d;
  fetch_tag_t             tag_q, tag_d;
  fetch_tag_t             hold_tag_q, hold_tag_d;
  logic [DATA_W-1:0]      hold_instr_q, hold_instr_d;
  logic [NUM_THREADS-1:0] halted_q, halted_d;

  logic [NUM_THREADS-1:0] redir_hit, eligible, grant;
  logic [TID_W-1:0]       grant_idx;
  logic                   grant_any;
  logic                   pres_vld, squash_inflight, out_vld, accept, issue;
  logic [DATA_W-1:0]      pres_instr;
  logic [TID_W-1:0]       pres_thread;
  logic [PC_W-1:0]        pres_pc;

  assign redir_hit = fetch_if.redirect_valid ?
                     (NUM_THREADS'(1) << fetch_if.redirect_thread) : '0;
  assign eligible  = thread_en_i & ~halted_q & ~redir_hit;

  rr_arbiter #(.N(NUM_THREADS), .IW(TID_W)) u_arb (
    .req_i   (eligible),
    .last_i  (last_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  always_comb begin
    pres_vld    = 1'b0;
    pres_instr  = '0;
    pres_thread = '0;
    pres_pc     = '0;
    if (hold_tag_q.valid) begin
      pres_vld    = 1'b1;
      pres_instr  = hold_instr_q;
      pres_thread = hold_tag_q.thread;
      pres_pc     = hold_tag_q.pc;
    end else if (tag_q.valid) begin
      pres_vld    = 1'b1;
      pres_instr  = fetch_if.imem_rdata;
      pres_thread = tag_q.thread;
      pres_pc     = tag_q.pc;
    end
  end

  // A fresh word from a thread being redirected never shows; a held one stays
  // visible this cycle so a concurrent accept still completes.
  assign squash_inflight = !hold_tag_q.valid && tag_q.valid && redir_hit[tag_q.thread];
  assign out_vld         = pres_vld && !squash_inflight;
  assign accept          = out_vld && fetch_if.out_ready;
  assign issue           = (!out_vld || fetch_if.out_ready) && grant_any;

  assign fetch_if.imem_addr   = imem_addr_q;
  assign fetch_if.imem_thread = imem_thread_q;
  assign fetch_if.out_valid   = out_vld;
  assign fetch_if.out_instr   = pres_instr;
  assign fetch_if.out_thread  = pres_thread;
  assign fetch_if.out_pc      = pres_pc;
  assign halted_o             = halted_q;

  always_comb begin
    last_d        = last_q;
    imem_addr_d   = imem_addr_q;
    imem_thread_d = imem_thread_q;
    tag_d         = tag_q;
    tag_d.valid   = 1'b0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      pc_d[i] = pc_q[i];
      if (issue && grant[i]) pc_d[i] = pc_q[i] + PC_W'(1);
      if (redir_hit[i])      pc_d[i] = fetch_if.redirect_pc;
    end
    if (issue) begin
      last_d        = grant_idx;
      imem_addr_d   = pc_q[grant_idx];
      imem_thread_d = grant_idx;
      tag_d         = '{valid: 1'b1, thread: grant_idx, pc: pc_q[grant_idx]};
    end
  end

  always_comb begin
    hold_tag_d   = hold_tag_q;
    hold_instr_d = hold_instr_q;
    if (hold_tag_q.valid) begin
      if (accept || redir_hit[hold_tag_q.thread]) hold_tag_d.valid = 1'b0;
    end else if (out_vld && !fetch_if.out_ready) begin
      hold_tag_d   = tag_q;
      hold_instr_d = fetch_if.imem_rdata;
    end
  end

  always_comb begin
`ifdef THREAD_FETCH_HALT_DETECT_EN
    halted_d = halted_q;
    if (accept && pres_instr == HALT_WORD) halted_d[pres_thread] = 1'b1;
    halted_d = halted_d & ~redir_hit;
`else
    halted_d = '0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_THREADS; i++) pc_q[i] <= '0;
      last_q        <= TID_W'(NUM_THREADS - 1);
      imem_addr_q   <= '0;
      imem_thread_q <= '0;
      tag_q         <= '0;
      hold_tag_q    <= '0;
      hold_instr_q  <= '0;
      halted_q      <= '0;
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) pc_q[i] <= pc_d[i];
      last_q        <= last_d;
      imem_addr_q   <= imem_addr_d;
      imem_thread_q <= imem_thread_d;
      tag_q         <= tag_d;
      hold_tag_q    <= hold_tag_d;
      hold_instr_q  <= hold_instr_d;
      halted_q      <= halted_d;
    end
  end

endmodule
